detect_ctrl_fsm: RTL and testbench

//  Parametrised system controller for the peak-detect datapath: load / run / done sequencing, BRAM-load and

---
 rtl/detect_ctrl_fsm.sv | 219 +++++++++++++++++++++
 tb/tb_detect_ctrl_fsm.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/detect_ctrl_fsm.sv
// Peak-detect system controller: load/run/done sequencing, detect timer, display select and LED drive.
// Optional run timeout enabled by defining DETECT_TIMEOUT_EN.
module detect_ctrl_fsm #(
   parameter int unsigned CLK_FREQ  = 50_000_000,
   parameter int unsigned PEAK_MAX  = 6,
   parameter int unsigned TIME_W    = 13,
   parameter int unsigned TICK_US   = 1,
   parameter int unsigned BLINK_MS  = 500,
   parameter int unsigned TIMEOUT_T = 8000,
   localparam int unsigned PNW      = $clog2(PEAK_MAX + 1)
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic                load_req,
   input  logic                start_evt,
   input  logic [PEAK_MAX-1:0] sel_evt,
   input  logic                detect_finish,
   input  logic [PNW-1:0]      detect_peak_num,
   output logic                detect_start,
   output logic                bram_wr_start,
   output logic [TIME_W-1:0]   detect_time,
   output logic [1:0]          disp_mode,
   output logic [PNW-1:0]      disp_peak_idx,
   output logic [2:0]          state_o,
   output logic                led_busy,
   output logic                led_load,
   output logic [PEAK_MAX-1:0] peak_led
);

   localparam int unsigned TICK_CYC = CLK_FREQ / 1_000_000 * TICK_US;
   localparam int unsigned MS_CYC   = CLK_FREQ / 1000;
   localparam int unsigned FAST_MS  = BLINK_MS / 4;
   localparam int unsigned TICK_W   = $clog2(TICK_CYC + 1);
   localparam int unsigned MS_W     = $clog2(MS_CYC + 1);
   localparam int unsigned BL_W     = $clog2(BLINK_MS + 1);
   localparam int unsigned FW       = $clog2(FAST_MS + 1);

   if (TIMEOUT_T >= (1 << TIME_W)) begin : g_bad_timeout
      $error("TIMEOUT_T must be below 2**TIME_W");
   end

   typedef enum logic [2:0] {
      S_INITED  = 3'd0,
      S_LOADING = 3'd1,
      S_PENDING = 3'd2,
      S_RUNNING = 3'd3,
      S_DONE    = 3'd4,
      S_ERROR   = 3'd5
   } state_t;

   typedef enum logic [1:0] {
      D_NONE = 2'd0,
      D_TIME = 2'd1,
      D_POS  = 2'd2,
      D_VAL  = 2'd3
   } disp_t;

   state_t              state, state_nx;
   disp_t               mode_q, mode_nx;
   logic [PNW-1:0]      idx_q, idx_nx;
   logic [TICK_W-1:0]   presc;
   logic                tick;
   logic [MS_W-1:0]     ms_presc;
   logic                ms_tick;
   logic [BL_W-1:0]     ms_cnt;
   logic [FW-1:0]       fast_cnt;
   logic                slow_ph, fast_ph;
   logic                sel_hit;
   logic [PNW-1:0]      sel_k;
   logic [PEAK_MAX-1:0] therm;
   logic                run_entry, done_entry;

   assign tick       = (state == S_RUNNING) && (presc == TICK_W'(TICK_CYC - 1));
   assign ms_tick    = (ms_presc == MS_W'(MS_CYC - 1));
   assign run_entry  = (state != S_RUNNING) && (state_nx == S_RUNNING);
   assign done_entry = (state != S_DONE) && (state_nx == S_DONE);

   assign state_o       = state;
   assign detect_start  = (state == S_RUNNING);
   assign bram_wr_start = (state == S_LOADING);
   assign disp_mode     = mode_q;
   assign disp_peak_idx = idx_q;

   always_ff @(posedge clk) begin
      if (!rstn) state <= S_INITED;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_INITED:  state_nx = S_PENDING;
         S_PENDING: begin
            if (load_req)       state_nx = S_LOADING;
            else if (start_evt) state_nx = S_RUNNING;
         end
         S_LOADING: if (!load_req) state_nx = S_PENDING;
         S_RUNNING: begin
            if (detect_finish) state_nx = S_DONE;
`ifdef DETECT_TIMEOUT_EN
            else if (detect_time >= TIME_W'(TIMEOUT_T)) state_nx = S_ERROR;
`endif
         end
         S_DONE, S_ERROR: if (start_evt) state_nx = S_PENDING;
         default:   state_nx = S_INITED;
      endcase
   end

   // Lowest-numbered select key wins when several arrive together.
   always_comb begin
      sel_hit = 1'b0;
      sel_k   = '0;
      therm   = '0;
      for (int unsigned i = 0; i < PEAK_MAX; i++) begin
         if (sel_evt[i] && !sel_hit) begin
            sel_hit = 1'b1;
            sel_k   = PNW'(i);
         end
         therm[i] = (PNW'(i) < detect_peak_num);
      end
   end

   always_comb begin
      mode_nx = D_NONE;
      idx_nx  = '1;
      if (state_nx == S_DONE) begin
         if (state != S_DONE) begin
            mode_nx = D_TIME;
            idx_nx  = '0;
         end else begin
            mode_nx = mode_q;
            idx_nx  = idx_q;
            if (sel_hit && (sel_k < detect_peak_num)) begin
               if (sel_k == idx_q && mode_q == D_POS)      mode_nx = D_VAL;
               else if (sel_k == idx_q && mode_q == D_VAL) mode_nx = D_POS;
               else begin
                  mode_nx = D_POS;
                  idx_nx  = sel_k;
               end
            end
         end
      end else if (state_nx == S_ERROR) begin
         mode_nx = D_TIME;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         mode_q <= D_NONE;
         idx_q  <= '1;
      end else begin
         mode_q <= mode_nx;
         idx_q  <= idx_nx;
      end
   end

   // Time clears as the FSM heads into an idle state so it reads 0 there with no lag.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         presc       <= '0;
         detect_time <= '0;
      end else begin
         if (run_entry || tick)       presc <= '0;
         else if (state == S_RUNNING) presc <= presc + 1'b1;
         if (state_nx == S_INITED || state_nx == S_LOADING || state_nx == S_PENDING)
            detect_time <= '0;
         else if (tick && detect_time != '1)
            detect_time <= detect_time + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn)           peak_led <= '0;
      else if (run_entry)  peak_led <= '0;
      else if (done_entry) peak_led <= therm;
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         ms_presc <= '0;
         ms_cnt   <= '0;
         fast_cnt <= '0;
         slow_ph  <= 1'b0;
         fast_ph  <= 1'b0;
      end else if (ms_tick) begin
         ms_presc <= '0;
         if (ms_cnt == BL_W'(BLINK_MS - 1)) begin
            ms_cnt  <= '0;
            slow_ph <= ~slow_ph;
         end else begin
            ms_cnt <= ms_cnt + 1'b1;
         end
         if (fast_cnt == FW'(FAST_MS - 1)) begin
            fast_cnt <= '0;
            fast_ph  <= ~fast_ph;
         end else begin
            fast_cnt <= fast_cnt + 1'b1;
         end
      end else begin
         ms_presc <= ms_presc + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         led_load <= 1'b0;
         led_busy <= 1'b0;
      end else begin
         led_load <= (state_nx == S_LOADING) ? slow_ph : 1'b1;
         case (state_nx)
            S_RUNNING: led_busy <= slow_ph;
            S_DONE:    led_busy <= 1'b1;
            S_ERROR:   led_busy <= fast_ph;
            default:   led_busy <= 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_detect_ctrl_fsm.sv
// Bench for detect_ctrl_fsm: three parameterisations share stimulus; expectations queue per edge.
// Timeout checks follow DETECT_TIMEOUT_EN as compiled.
module tb_detect_ctrl_fsm;

   logic       clk = 1'b0;
   logic       rstn;
   logic       load_req, start_evt, detect_finish;
   logic [5:0] sel_evt;
   logic [2:0] detect_peak_num;

   logic [2:0]  a_state, b_state, c_state;
   logic [1:0]  a_mode, b_mode, c_mode;
   logic [2:0]  a_idx, b_idx, c_idx;
   logic [12:0] a_time, c_time;
   logic [3:0]  b_time;
   logic [5:0]  a_pled, b_pled, c_pled;
   logic        a_lload, b_lload, c_lload, a_lbusy, b_lbusy, c_lbusy;
   logic        a_dst, b_dst, c_dst, a_bram, b_bram, c_bram;

   always #5 clk = ~clk;

   detect_ctrl_fsm #(.CLK_FREQ(2_000_000), .BLINK_MS(4)) dut_a (
      .clk(clk), .rstn(rstn), .load_req(load_req), .start_evt(start_evt), .sel_evt(sel_evt),
      .detect_finish(detect_finish), .detect_peak_num(detect_peak_num), .detect_start(a_dst),
      .bram_wr_start(a_bram), .detect_time(a_time), .disp_mode(a_mode), .disp_peak_idx(a_idx),
      .state_o(a_state), .led_busy(a_lbusy), .led_load(a_lload), .peak_led(a_pled));

   detect_ctrl_fsm #(.CLK_FREQ(1_000_000), .TIME_W(4), .TIMEOUT_T(12), .BLINK_MS(4)) dut_b (
      .clk(clk), .rstn(rstn), .load_req(load_req), .start_evt(start_evt), .sel_evt(sel_evt),
      .detect_finish(detect_finish), .detect_peak_num(detect_peak_num), .detect_start(b_dst),
      .bram_wr_start(b_bram), .detect_time(b_time), .disp_mode(b_mode), .disp_peak_idx(b_idx),
      .state_o(b_state), .led_busy(b_lbusy), .led_load(b_lload), .peak_led(b_pled));

   detect_ctrl_fsm #(.CLK_FREQ(1_000_000), .TIMEOUT_T(100), .BLINK_MS(4)) dut_c (
      .clk(clk), .rstn(rstn), .load_req(load_req), .start_evt(start_evt), .sel_evt(sel_evt),
      .detect_finish(detect_finish), .detect_peak_num(detect_peak_num), .detect_start(c_dst),
      .bram_wr_start(c_bram), .detect_time(c_time), .disp_mode(c_mode), .disp_peak_idx(c_idx),
      .state_o(c_state), .led_busy(c_lbusy), .led_load(c_lload), .peak_led(c_pled));

   localparam int unsigned F_ST = 0, F_MODE = 1, F_IDX = 2, F_TIME = 3, F_PLED = 4;
   localparam int unsigned F_LLOAD = 5, F_LBUSY = 6, F_DST = 7, F_BRAM = 8;
   string fname [9] = '{"state", "disp_mode", "disp_idx", "time", "peak_led",
                        "led_load", "led_busy", "detect_start", "bram_wr_start"};

   typedef struct {
      string       tag;
      int unsigned dut;
      int unsigned fld;
      int unsigned exp;
   } sb_t;
   sb_t sb [$];

   typedef struct {
      int unsigned load, start, sel, fin, pnum;
      int unsigned st, mode, idx, tim, pled, lload, lbusy;
   } vec_t;
   vec_t vecs [16];

   int checks = 0;
   int errors = 0;

   function automatic int unsigned pick(int unsigned d, int unsigned a, int unsigned b, int unsigned c);
      return (d == 0) ? a : (d == 1) ? b : c;
   endfunction

   function automatic int unsigned act(int unsigned d, int unsigned f);
      case (f)
         F_ST:    return pick(d, a_state, b_state, c_state);
         F_MODE:  return pick(d, a_mode, b_mode, c_mode);
         F_IDX:   return pick(d, a_idx, b_idx, c_idx);
         F_TIME:  return pick(d, a_time, b_time, c_time);
         F_PLED:  return pick(d, a_pled, b_pled, c_pled);
         F_LLOAD: return pick(d, a_lload, b_lload, c_lload);
         F_LBUSY: return pick(d, a_lbusy, b_lbusy, c_lbusy);
         F_DST:   return pick(d, a_dst, b_dst, c_dst);
         default: return pick(d, a_bram, b_bram, c_bram);
      endcase
   endfunction

   task automatic push(input int unsigned d, input int unsigned f, input int unsigned v, input string tag);
      sb_t e;
      e.tag = tag; e.dut = d; e.fld = f; e.exp = v;
      sb.push_back(e);
   endtask

   // One clock edge, then compare everything queued for that edge.
   task automatic step();
      sb_t e;
      int unsigned a;
      @(posedge clk);
      #1;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         a = act(e.dut, e.fld);
         checks++;
         if (a != e.exp) begin
            errors++;
            $display("FAIL %s dut%0d %s: got %0d want %0d", e.tag, e.dut, fname[e.fld], a, e.exp);
         end
      end
   endtask

   task automatic do_reset();
      rstn = 1'b0; load_req = 1'b0; start_evt = 1'b0; sel_evt = '0;
      detect_finish = 1'b0; detect_peak_num = '0;
      step();
      step();
      rstn = 1'b1;
      step();
   endtask

   int toggles;
   logic prev;

   initial begin
      vecs[0]  = '{0, 0, 0,  0, 0, 2, 0, 7, 0, 0, 1, 0};
      vecs[1]  = '{1, 0, 0,  0, 0, 1, 0, 7, 0, 0, 0, 0};
      vecs[2]  = '{1, 0, 0,  0, 0, 1, 0, 7, 0, 0, 0, 0};
      vecs[3]  = '{0, 1, 0,  0, 0, 2, 0, 7, 0, 0, 1, 0};
      vecs[4]  = '{0, 1, 0,  0, 0, 3, 0, 7, 0, 0, 1, 0};
      vecs[5]  = '{1, 0, 0,  0, 0, 3, 0, 7, 0, 0, 1, 0};
      vecs[6]  = '{0, 0, 0,  1, 3, 4, 1, 0, 1, 7, 1, 1};
      vecs[7]  = '{1, 0, 2,  0, 3, 4, 2, 1, 1, 7, 1, 1};
      vecs[8]  = '{0, 0, 2,  0, 3, 4, 3, 1, 1, 7, 1, 1};
      vecs[9]  = '{0, 0, 4,  0, 3, 4, 2, 2, 1, 7, 1, 1};
      vecs[10] = '{0, 0, 16, 0, 3, 4, 2, 2, 1, 7, 1, 1};
      vecs[11] = '{0, 0, 10, 0, 3, 4, 2, 1, 1, 7, 1, 1};
      vecs[12] = '{0, 0, 1,  0, 3, 4, 2, 0, 1, 7, 1, 1};
      vecs[13] = '{0, 0, 1,  0, 3, 4, 3, 0, 1, 7, 1, 1};
      vecs[14] = '{0, 0, 8,  0, 3, 4, 3, 0, 1, 7, 1, 1};
      vecs[15] = '{0, 1, 1,  0, 3, 2, 0, 7, 0, 7, 1, 0};

      // Reset values
      rstn = 1'b0; load_req = 1'b0; start_evt = 1'b0; sel_evt = '0;
      detect_finish = 1'b0; detect_peak_num = '0;
      step();
      push(0, F_ST, 0, "rst"); push(0, F_MODE, 0, "rst"); push(0, F_IDX, 7, "rst");
      push(0, F_TIME, 0, "rst"); push(0, F_PLED, 0, "rst"); push(0, F_LLOAD, 0, "rst");
      push(0, F_LBUSY, 0, "rst"); push(0, F_DST, 0, "rst"); push(0, F_BRAM, 0, "rst");
      step();
      rstn = 1'b1;

      // Sequencing and display select table
      for (int i = 0; i < 16; i++) begin
         string t;
         t = $sformatf("vec%0d", i);
         load_req = vecs[i].load[0]; start_evt = vecs[i].start[0];
         sel_evt = 6'(vecs[i].sel); detect_finish = vecs[i].fin[0];
         detect_peak_num = 3'(vecs[i].pnum);
         push(0, F_ST, vecs[i].st, t);      push(0, F_MODE, vecs[i].mode, t);
         push(0, F_IDX, vecs[i].idx, t);    push(0, F_TIME, vecs[i].tim, t);
         push(0, F_PLED, vecs[i].pled, t);  push(0, F_LLOAD, vecs[i].lload, t);
         push(0, F_LBUSY, vecs[i].lbusy, t);
         push(0, F_DST, (vecs[i].st == 3) ? 1 : 0, t);
         push(0, F_BRAM, (vecs[i].st == 1) ? 1 : 0, t);
         step();
      end
      load_req = 1'b0; start_evt = 1'b0; sel_evt = '0;

      // 2500 us run at 2 cycles per tick
      detect_peak_num = 3'd2;
      start_evt = 1'b1;
      push(0, F_ST, 3, "run_start");
      step();
      start_evt = 1'b0;
      repeat (4998) step();
      push(0, F_TIME, 2499, "run_pre"); push(0, F_ST, 3, "run_pre");
      step();
      detect_finish = 1'b1;
      push(0, F_ST, 4, "run_done"); push(0, F_TIME, 2500, "run_done");
      push(0, F_MODE, 1, "run_done"); push(0, F_IDX, 0, "run_done");
      push(0, F_DST, 0, "run_done"); push(0, F_PLED, 3, "run_done");
      step();
      detect_finish = 1'b0;

      // peak count above PEAK_MAX, then reset in DONE and mid-run
      start_evt = 1'b1;
      push(0, F_ST, 2, "rerun"); step();
      push(0, F_ST, 3, "rerun"); push(0, F_PLED, 0, "rerun"); step();
      start_evt = 1'b0;
      detect_peak_num = 3'd7; detect_finish = 1'b1;
      push(0, F_ST, 4, "pmax"); push(0, F_PLED, 63, "pmax"); step();
      detect_finish = 1'b0;
      rstn = 1'b0;
      push(0, F_ST, 0, "rst_done"); push(0, F_PLED, 0, "rst_done");
      push(0, F_MODE, 0, "rst_done"); push(0, F_IDX, 7, "rst_done"); push(0, F_LBUSY, 0, "rst_done");
      step();
      rstn = 1'b1;
      step();
      start_evt = 1'b1;
      push(0, F_ST, 3, "rst_run"); step();
      start_evt = 1'b0;
      step(); step();
      push(0, F_TIME, 1, "pre_rst"); push(0, F_DST, 1, "pre_rst");
      step();
      rstn = 1'b0;
      push(0, F_ST, 0, "rst_run"); push(0, F_DST, 0, "rst_run");
      push(0, F_TIME, 0, "rst_run"); push(0, F_PLED, 0, "rst_run");
      step();

      // TIME_W=4 instance
      do_reset();
      start_evt = 1'b1;
      push(1, F_ST, 3, "sat_start"); push(1, F_TIME, 0, "sat_start");
      step();
      start_evt = 1'b0;
`ifndef DETECT_TIMEOUT_EN
      repeat (14) step();
      push(1, F_TIME, 15, "sat15"); push(1, F_ST, 3, "sat15"); step();
      repeat (4) step();
      push(1, F_TIME, 15, "sat20"); push(1, F_ST, 3, "sat20"); step();
      detect_finish = 1'b1;
      push(1, F_ST, 4, "sat_done"); push(1, F_TIME, 15, "sat_done"); step();
`else
      repeat (11) step();
      push(1, F_TIME, 12, "tmo_edge"); push(1, F_ST, 3, "tmo_edge"); step();
      detect_finish = 1'b1;
      push(1, F_ST, 4, "fin_vs_tmo"); push(1, F_TIME, 13, "fin_vs_tmo"); step();
`endif
      detect_finish = 1'b0;

      // TIMEOUT_T=100 instance
      do_reset();
      start_evt = 1'b1;
      push(2, F_ST, 3, "tmo_start"); step();
      start_evt = 1'b0;
`ifdef DETECT_TIMEOUT_EN
      repeat (99) step();
      push(2, F_ST, 3, "tmo100"); push(2, F_TIME, 100, "tmo100"); step();
      push(2, F_ST, 5, "err"); push(2, F_MODE, 1, "err"); push(2, F_IDX, 7, "err");
      push(2, F_DST, 0, "err");
      step();
      toggles = 0;
      prev = c_lbusy;
      for (int i = 0; i < 2500; i++) begin
         @(posedge clk);
         #1;
         if (c_lbusy != prev) toggles++;
         prev = c_lbusy;
      end
      checks++;
      if (toggles < 2 || toggles > 3) begin
         errors++;
         $display("FAIL err_blink: got %0d led_busy toggles in 2500 cycles want 2..3", toggles);
      end
      start_evt = 1'b1;
      push(2, F_ST, 2, "err_ack"); push(2, F_TIME, 0, "err_ack");
      push(2, F_MODE, 0, "err_ack"); push(2, F_IDX, 7, "err_ack");
      step();
`else
      repeat (150) step();
      push(2, F_ST, 3, "no_tmo"); push(2, F_TIME, 151, "no_tmo"); step();
`endif
      start_evt = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
